// File: rtl/crc32_frame_engine.sv
// Framed reflected CRC-32 (Ethernet FCS) engine, DATA_W bits per beat, with end-of-frame residue check.
// Optional minimum-length check and runt output enabled by defining CRC_LEN_CHECK_EN.
module crc32_frame_engine #(
    parameter int          DATA_W    = 2,
    parameter logic [31:0] POLY      = 32'hEDB88320,
    parameter logic [31:0] INIT      = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT   = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE   = 32'hDEBB20E3,
    parameter int          MIN_BYTES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [DATA_W-1:0] axiid,
    input  logic              axiil,
    input  logic              abort,
    output logic [31:0]       axiod,
    output logic              frame_valid,
    output logic [31:0]       frame_crc,
    output logic              fcs_ok,
`ifdef CRC_LEN_CHECK_EN
    output logic              runt,
`endif
    output logic              busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d, crc_n;
    logic        fv_q, fv_d;
    logic [31:0] fcrc_q, fcrc_d;
    logic        ok_q, ok_d;
    logic        beat, done, runt_now;

    // Bit-serial reflected update, unrolled across the whole beat; bit 0 is first on the wire.
    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [DATA_W-1:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < DATA_W; i++) begin
            fb = c[0] ^ d[i];
            c  = (c >> 1) ^ (fb ? POLY : 32'h0);
        end
        return c;
    endfunction

    assign crc_n = crc_step(crc_q, axiid);
    // abort wins over a beat presented in the same cycle
    assign beat  = axiiv && !abort;
    assign done  = beat && axiil;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort)     state_d = S_IDLE;
        else if (beat) state_d = axiil ? S_IDLE : S_RUN;
    end

    always_comb begin
        busy = (state_q == S_RUN);
    end

`ifdef CRC_LEN_CHECK_EN
    localparam logic [16:0] MIN_BITS = 17'(MIN_BYTES * 8);

    logic [15:0] bits_q, bits_d, bits_sat;
    logic [16:0] bits_sum;
    logic        runt_q, runt_d;

    assign bits_sum = {1'b0, bits_q} + 17'(DATA_W);
    assign bits_sat = bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
    assign runt_now = done && ({1'b0, bits_sat} < MIN_BITS);

    always_comb begin
        bits_d = bits_q;
        runt_d = runt_q;
        if (abort || done) bits_d = 16'd0;
        else if (beat)     bits_d = bits_sat;
        if (done)          runt_d = runt_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q <= 16'd0;
            runt_q <= 1'b0;
        end else begin
            bits_q <= bits_d;
            runt_q <= runt_d;
        end
    end

    assign runt = runt_q;
`else
    assign runt_now = 1'b0;
`endif

    always_comb begin
        crc_d  = crc_q;
        fv_d   = done;
        fcrc_d = fcrc_q;
        ok_d   = ok_q;
        if (abort)     crc_d = INIT;
        else if (beat) crc_d = axiil ? INIT : crc_n;
        if (done) begin
            fcrc_d = crc_n ^ XOR_OUT;
            ok_d   = (crc_n == RESIDUE) && !runt_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q  <= INIT;
            fv_q   <= 1'b0;
            fcrc_q <= 32'h0;
            ok_q   <= 1'b0;
        end else begin
            crc_q  <= crc_d;
            fv_q   <= fv_d;
            fcrc_q <= fcrc_d;
            ok_q   <= ok_d;
        end
    end

    assign axiod       = crc_q ^ XOR_OUT;
    assign frame_valid = fv_q;
    assign frame_crc   = fcrc_q;
    assign fcs_ok      = ok_q;

endmodule
